// File: rtl/membrane_spike_store.sv
// Membrane register file and spike packer closing the SNN recurrence loop: replay, collect, emit per timestep.
// Optional macro LEAK_EN: replayed membranes are reduced by LEAK with saturation at zero.
module membrane_spike_store #(
  parameter int WIDTH        = 8,
  parameter int NUM_NEURON   = 3,
  parameter int NUM_TIMESTEP = 4,
  parameter int LEAK         = 1,
  parameter int TS_W         = (NUM_TIMESTEP > 1) ? $clog2(NUM_TIMESTEP) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      mem_in_data,
  input  logic                  spk_in,
  input  logic                  mem_in_valid,
  output logic                  mem_in_ready,
  output logic [NUM_NEURON-1:0] spike_word,
  output logic                  spike_valid,
  input  logic                  spike_ready,
  output logic [WIDTH-1:0]      mem_rd_data,
  output logic                  mem_rd_valid,
  input  logic                  mem_rd_ready,
  output logic [TS_W-1:0]       timestep,
  output logic                  done
);

  localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);
  localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(NUM_TIMESTEP - 1);
  // With the leak disabled the amount is zero, so the saturating subtract returns mem[idx] unchanged.
`ifdef LEAK_EN
  localparam logic [WIDTH-1:0] LEAK_AMT = WIDTH'(LEAK);
`else
  localparam logic [WIDTH-1:0] LEAK_AMT = {WIDTH{1'b0}};
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REPLAY  = 3'd1,
    S_COLLECT = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TS_W-1:0]        ts_q;
  logic [NUM_NEURON-1:0]  spike_q;
  logic [WIDTH-1:0]       mem_q [NUM_NEURON];
  logic [WIDTH-1:0]       rd_raw_s;

  // Timestep sequencer: owns state, neuron index, timestep count, membrane file and spike word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      ts_q    <= {TS_W{1'b0}};
      spike_q <= {NUM_NEURON{1'b0}};
      for (int i = 0; i < NUM_NEURON; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REPLAY;
          idx_q   <= {IDX_W{1'b0}};
        end
        S_REPLAY: begin
          if (mem_rd_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q   <= {IDX_W{1'b0}};
              spike_q <= {NUM_NEURON{1'b0}};
              state_q <= S_COLLECT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_COLLECT: begin
          if (mem_in_valid) begin
            mem_q[idx_q]   <= mem_in_data;
            spike_q[idx_q] <= spk_in;
            if (idx_q == LAST_IDX) begin
              idx_q   <= {IDX_W{1'b0}};
              state_q <= S_EMIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_EMIT: begin
          if (spike_ready) begin
            if (ts_q == LAST_TS) begin
              state_q <= S_DONE;
            end else begin
              ts_q    <= ts_q + TS_W'(1);
              state_q <= S_REPLAY;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign rd_raw_s     = mem_q[idx_q];
  assign mem_rd_data  = (rd_raw_s > LEAK_AMT) ? (rd_raw_s - LEAK_AMT) : {WIDTH{1'b0}};
  assign mem_rd_valid = (state_q == S_REPLAY);
  assign mem_in_ready = (state_q == S_COLLECT);
  assign spike_valid  = (state_q == S_EMIT);
  assign spike_word   = spike_q;
  assign timestep     = ts_q;
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_membrane_spike_store.sv
// Randomized self-checking bench for membrane_spike_store against a transfer-counting reference model.
module tb_membrane_spike_store;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int NT = 4;
  localparam int TW = 2;
`ifdef LEAK_EN
  localparam int LEAK_T = 1;
`else
  localparam int LEAK_T = 0;
`endif

  localparam int P_IDLE = 0, P_REP = 1, P_COL = 2, P_EMIT = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  mem_in_data = '0;
  logic          spk_in = 1'b0;
  logic          mem_in_valid = 1'b0;
  logic          mem_in_ready;
  logic [N-1:0]  spike_word;
  logic          spike_valid;
  logic          spike_ready = 1'b0;
  logic [W-1:0]  mem_rd_data;
  logic          mem_rd_valid;
  logic          mem_rd_ready = 1'b0;
  logic [TW-1:0] timestep;
  logic          done;

  membrane_spike_store #(.WIDTH(W), .NUM_NEURON(N), .NUM_TIMESTEP(NT), .LEAK(1)) dut (
    .clk(clk), .rst(rst),
    .mem_in_data(mem_in_data), .spk_in(spk_in), .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready),
    .spike_word(spike_word), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
    .timestep(timestep), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: phase, transfers done in this phase, timestep, stored membranes and spikes
  int       phase;
  int       cnt;
  int       ts;
  int       mem_m [N];
  bit [N-1:0] spk_m;
  bit       acc_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int leak(input int v);
    return (v > LEAK_T) ? v - LEAK_T : 0;
  endfunction

  task automatic model_reset;
    phase = P_IDLE; cnt = 0; ts = 0; spk_m = '0; acc_q = 1'b0;
    for (int i = 0; i < N; i++) mem_m[i] = 0;
  endtask

  task automatic check_outputs;
    chk("mem_in_ready", int'(mem_in_ready), int'(phase == P_COL));
    chk("mem_rd_valid", int'(mem_rd_valid), int'(phase == P_REP));
    chk("spike_valid", int'(spike_valid), int'(phase == P_EMIT));
    chk("done", int'(done), int'(phase == P_DONE));
    chk("timestep", int'(timestep), ts);
    if (phase == P_REP) chk("mem_rd_data", int'(mem_rd_data), leak(mem_m[cnt]));
    if (phase == P_EMIT) chk("spike_word", int'(spike_word), int'(spk_m));
    if (rst) begin
      chk("rst_spike_word", int'(spike_word), 0);
      chk("rst_mem_rd_data", int'(mem_rd_data), 0);
    end
  endtask

  task automatic model_update;
    acc_q = mem_in_valid && (phase == P_COL);
    case (phase)
      P_IDLE: begin phase = P_REP; cnt = 0; end
      P_REP: if (mem_rd_ready) begin
        cnt++;
        if (cnt == N) begin phase = P_COL; cnt = 0; end
      end
      P_COL: if (mem_in_valid) begin
        mem_m[cnt] = int'(mem_in_data);
        spk_m[cnt] = spk_in;
        cnt++;
        if (cnt == N) begin phase = P_EMIT; cnt = 0; end
      end
      P_EMIT: if (spike_ready) begin
        if (ts == NT - 1) phase = P_DONE;
        else begin ts++; phase = P_REP; cnt = 0; end
      end
      default: phase = P_DONE;
    endcase
  endtask

  task automatic step;
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_in_valid = 1'b0; mem_rd_ready = 1'b0; spike_ready = 1'b0;
    mem_in_data = '0; spk_in = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic new_pair(input bit force_valid);
    if (!mem_in_valid || acc_q) begin
      mem_in_valid = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
      mem_in_data  = W'($urandom);
      spk_in       = 1'($urandom);
    end
  endtask

  int  vals [N] = '{10, 5, 63};
  bit  spks [N] = '{1'b0, 1'b1, 1'b0};
  int  lit_rd [N];
  int  si;
  int  hold;

  initial begin
    for (int i = 0; i < N; i++) lit_rd[i] = (vals[i] > LEAK_T) ? vals[i] - LEAK_T : 0;

    // directed: replay of zeros, fixed collect, held EMIT, early mem_in_valid, replay of stored values
    do_reset();
    si = 0; hold = 0;
    for (int c = 0; c < 40; c++) begin
      mem_rd_ready = 1'b1;
      mem_in_valid = (si < N);
      mem_in_data  = (si < N) ? W'(vals[si]) : '0;
      spk_in       = (si < N) ? spks[si] : 1'b0;
      spike_ready  = (phase == P_EMIT) && (hold >= 5);
      if (phase == P_REP && ts == 0) chk("lit_replay_zero", int'(mem_rd_data), 0);
      if (phase == P_EMIT) begin
        chk("lit_spike_word", int'(spike_word), 2);
        hold++;
      end
      if (phase == P_REP && ts == 1) chk("lit_replay", int'(mem_rd_data), lit_rd[cnt]);
      if (mem_in_valid && phase == P_COL) si++;
      step();
      if (phase == P_COL && ts == 1) break;
    end
    chk("lit_hold_cycles", hold, 6);

    // reset after two pairs of the second collect
    for (int c = 0; c < 10 && cnt < 2; c++) begin
      new_pair(1'b1);
      step();
    end
    do_reset();
    mem_rd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (phase == P_REP) chk("lit_replay_after_rst", int'(mem_rd_data), 0);
      step();
    end

    // randomized runs, each drained to completion
    for (int run = 0; run < 3; run++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        new_pair(1'b0);
        mem_rd_ready = ($urandom_range(0, 3) != 0);
        spike_ready  = ($urandom_range(0, 2) != 0);
        step();
        if (run == 1 && c == 70) do_reset();
      end
      for (int c = 0; c < 80; c++) begin
        new_pair(1'b1);
        mem_rd_ready = 1'b1;
        spike_ready  = 1'b1;
        step();
      end
      chk("lit_done_end", int'(done), 1);
      chk("lit_ts_end", int'(timestep), NT - 1);
      chk("lit_ready_end", int'(mem_in_ready | mem_rd_valid | spike_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
